// File: rtl/stack_pointer_unit.sv
// -----------------------------------------------------------------------------
// stack_pointer_unit
//
// Purpose:
//   Stack control unit placed directly upstream of the register bank. It owns
//   the authoritative stack pointer, runs PUSH/POP transactions against data
//   memory through a req/ack handshake, and publishes the new $rp value
//   together with a one-cycle load strobe (pilha_e) so the bank can mirror it.
//   The stack grows downward, one word per entry, starting from RP_TOP.
//   PUSH pre-decrements the pointer and POP post-increments it.
//
// Optional feature:
//   Define STACK_WATERMARK_EN to add output max_depth, which holds the deepest
//   stack occupancy reached since reset. When the macro is undefined, the port
//   and its logic are absent.
//
// Ports:
//   clock      in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset
//   push       in   1       push request (sampled only in IDLE)
//   pop        in   1       pop request (sampled only in IDLE)
//   dado_push  in   32      word to push, captured together with push
//   ready      out  1       high while IDLE (a request is accepted this cycle)
//   mem_addr   out  ADDR_W  memory address of the current transaction
//   mem_wdata  out  32      memory write data
//   mem_we     out  1       memory write request, held until mem_ack
//   mem_re     out  1       memory read request, held until mem_ack
//   mem_ack    in   1       memory completion (sampled only in wait states)
//   mem_rdata  in   32      memory read data, valid with mem_ack
//   rp         out  ADDR_W  current stack pointer
//   pilha_e    out  1       one-cycle strobe: bank must load rp
//   pop_dado   out  32      popped word
//   pop_valid  out  1       one-cycle strobe: pop_dado is valid
//   overflow   out  1       one-cycle pulse: push refused, stack full
//   underflow  out  1       one-cycle pulse: pop refused, stack empty
//   max_depth  out  ADDR_W  (STACK_WATERMARK_EN only) deepest occupancy seen
// -----------------------------------------------------------------------------
module stack_pointer_unit #(
  parameter int unsigned           ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]     RP_TOP     = ADDR_W'(224),
  parameter logic [ADDR_W-1:0]     STACK_BASE = ADDR_W'(160)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [31:0]       dado_push,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] rp,
`ifdef STACK_WATERMARK_EN
  output logic [ADDR_W-1:0] max_depth,
`endif
  output logic              pilha_e,
  output logic [31:0]       pop_dado,
  output logic              pop_valid,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_W = 2'd1,
    S_WAIT_R = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  // State and registered outputs
  state_t              r_state;
  logic [ADDR_W-1:0]   r_rp;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_mem_we;
  logic                r_mem_re;
  logic                r_pilha_e;
  logic [31:0]         r_pop_dado;
  logic                r_pop_valid;
  logic                r_overflow;
  logic                r_underflow;

  // Next-state / next-output values
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_rp_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [31:0]         w_mem_wdata_nxt;
  logic                w_mem_we_nxt;
  logic                w_mem_re_nxt;
  logic                w_pilha_e_nxt;
  logic [31:0]         w_pop_dado_nxt;
  logic                w_pop_valid_nxt;
  logic                w_overflow_nxt;
  logic                w_underflow_nxt;

  // Request decode: simultaneous push and pop is illegal and starts nothing
  logic                w_push_only;
  logic                w_pop_only;
  logic                w_full;
  logic                w_empty;

  assign w_push_only = push & ~pop;
  assign w_pop_only  = pop & ~push;
  assign w_full      = (r_rp == STACK_BASE);
  assign w_empty     = (r_rp == RP_TOP);

`ifdef STACK_WATERMARK_EN
  logic [ADDR_W-1:0]   r_max_depth;
  logic [ADDR_W-1:0]   w_max_depth_nxt;
  logic [ADDR_W-1:0]   w_depth_after_push;

  // Occupancy once the pending push commits (new rp = rp - 1)
  assign w_depth_after_push = RP_TOP - (r_rp - ONE);
`endif

  // State register and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rp        <= RP_TOP;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_pilha_e   <= 1'b0;
      r_pop_dado  <= 32'h0000_0000;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
`ifdef STACK_WATERMARK_EN
      r_max_depth <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_rp        <= w_rp_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_pilha_e   <= w_pilha_e_nxt;
      r_pop_dado  <= w_pop_dado_nxt;
      r_pop_valid <= w_pop_valid_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
`ifdef STACK_WATERMARK_EN
      r_max_depth <= w_max_depth_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_push_only && !w_full) begin
          w_state_nxt = S_WAIT_W;
        end else if (w_pop_only && !w_empty) begin
          w_state_nxt = S_WAIT_R;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_W: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_W;
        end
      end
      S_WAIT_R: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_R;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    // Data/address registers hold, pulses fall back to zero every cycle
    w_rp_nxt        = r_rp;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = r_mem_we;
    w_mem_re_nxt    = r_mem_re;
    w_pilha_e_nxt   = 1'b0;
    w_pop_dado_nxt  = r_pop_dado;
    w_pop_valid_nxt = 1'b0;
    w_overflow_nxt  = 1'b0;
    w_underflow_nxt = 1'b0;
`ifdef STACK_WATERMARK_EN
    w_max_depth_nxt = r_max_depth;
`endif
    case (r_state)
      S_IDLE: begin
        w_mem_we_nxt = 1'b0;
        w_mem_re_nxt = 1'b0;
        if (w_push_only) begin
          if (w_full) begin
            w_overflow_nxt = 1'b1;
          end else begin
            // Pre-decrement: the new entry lives just below the current top
            w_mem_addr_nxt  = r_rp - ONE;
            w_mem_wdata_nxt = dado_push;
            w_mem_we_nxt    = 1'b1;
          end
        end else if (w_pop_only) begin
          if (w_empty) begin
            w_underflow_nxt = 1'b1;
          end else begin
            w_mem_addr_nxt = r_rp;
            w_mem_re_nxt   = 1'b1;
          end
        end else begin
          w_mem_we_nxt = 1'b0;
        end
      end
      S_WAIT_W: begin
        if (mem_ack) begin
          w_rp_nxt      = r_rp - ONE;
          w_pilha_e_nxt = 1'b1;
          w_mem_we_nxt  = 1'b0;
`ifdef STACK_WATERMARK_EN
          if (w_depth_after_push > r_max_depth) begin
            w_max_depth_nxt = w_depth_after_push;
          end else begin
            w_max_depth_nxt = r_max_depth;
          end
`endif
        end else begin
          w_mem_we_nxt = 1'b1;
        end
      end
      S_WAIT_R: begin
        if (mem_ack) begin
          w_pop_dado_nxt  = mem_rdata;
          w_rp_nxt        = r_rp + ONE;
          w_pilha_e_nxt   = 1'b1;
          w_pop_valid_nxt = 1'b1;
          w_mem_re_nxt    = 1'b0;
        end else begin
          w_mem_re_nxt = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: drop both memory requests on the way back to IDLE
        w_mem_we_nxt = 1'b0;
        w_mem_re_nxt = 1'b0;
      end
    endcase
  end

  assign ready     = (r_state == S_IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign rp        = r_rp;
  assign pilha_e   = r_pilha_e;
  assign pop_dado  = r_pop_dado;
  assign pop_valid = r_pop_valid;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`ifdef STACK_WATERMARK_EN
  assign max_depth = r_max_depth;
`endif

endmodule

// File: tb/tb_stack_pointer_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_pointer_unit
//
// Directed, table-driven bench for stack_pointer_unit. A table of single
// transactions with hand-computed results drives the main flow; hand-written
// sequences cover fill-to-full/drain, requests held during a wait state,
// reset in the middle of a push, and the optional watermark.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_stack_pointer_unit;

  logic        clock;
  logic        reset_n;
  logic        push;
  logic        pop;
  logic [31:0] dado_push;
  logic        ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] rp;
  logic        pilha_e;
  logic [31:0] pop_dado;
  logic        pop_valid;
  logic        overflow;
  logic        underflow;
`ifdef STACK_WATERMARK_EN
  logic [31:0] max_depth;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [0:255];

  typedef struct {
    logic [1:0]  op;        // 1 push, 2 pop, 3 both
    logic [31:0] data;
    int          delay;     // wait cycles before mem_ack
    logic [31:0] exp_addr;
    logic [31:0] exp_rp;
    logic [31:0] exp_pop;
    logic        exp_ov;
    logic        exp_un;
  } vec_t;

  vec_t vecs [10];

  stack_pointer_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .dado_push (dado_push),
    .ready     (ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rp        (rp),
`ifdef STACK_WATERMARK_EN
    .max_depth (max_depth),
`endif
    .pilha_e   (pilha_e),
    .pop_dado  (pop_dado),
    .pop_valid (pop_valid),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    mem_ack   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // One complete transaction starting at a falling edge, ending on a falling edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                        input int delay, input logic [31:0] exp_addr,
                        input logic [31:0] exp_rp, input logic [31:0] exp_pop,
                        input logic exp_ov, input logic exp_un);
    logic        refused;
    logic [31:0] rp_before;
    refused   = (op == 2'd3) || exp_ov || exp_un;
    rp_before = (op == 2'd1) ? exp_rp + 32'd1 : exp_rp - 32'd1;
    chk({tag, ".ready_pre"}, {31'd0, ready}, 32'd1);
    push      = op[0];
    pop       = op[1];
    dado_push = data;
    @(negedge clock);
    push      = 1'b0;
    pop       = 1'b0;
    dado_push = ~data;
    if (refused) begin
      chk({tag, ".overflow"},  {31'd0, overflow},  {31'd0, exp_ov});
      chk({tag, ".underflow"}, {31'd0, underflow}, {31'd0, exp_un});
      chk({tag, ".mem_we"},    {31'd0, mem_we},    32'd0);
      chk({tag, ".mem_re"},    {31'd0, mem_re},    32'd0);
      chk({tag, ".pilha_e"},   {31'd0, pilha_e},   32'd0);
      chk({tag, ".rp"},        rp,                 exp_rp);
      chk({tag, ".ready"},     {31'd0, ready},     32'd1);
      @(negedge clock);
      chk({tag, ".ov_1cyc"},   {31'd0, overflow},  32'd0);
      chk({tag, ".un_1cyc"},   {31'd0, underflow}, 32'd0);
      chk({tag, ".mem_re2"},   {31'd0, mem_re},    32'd0);
    end else begin
      chk({tag, ".mem_we"},   {31'd0, mem_we}, {31'd0, op[0]});
      chk({tag, ".mem_re"},   {31'd0, mem_re}, {31'd0, op[1]});
      chk({tag, ".mem_addr"}, mem_addr,        exp_addr);
      chk({tag, ".ready_busy"}, {31'd0, ready}, 32'd0);
      if (op[0]) chk({tag, ".mem_wdata"}, mem_wdata, data);
      for (int i = 0; i < delay; i++) begin
        @(negedge clock);
        chk({tag, ".hold_addr"}, mem_addr, exp_addr);
        chk({tag, ".hold_req"},  {30'd0, mem_re, mem_we}, {30'd0, op[1], op[0]});
        chk({tag, ".hold_rp"},   rp, rp_before);
        if (op[0]) chk({tag, ".hold_wdata"}, mem_wdata, data);
      end
      mem_ack   = 1'b1;
      mem_rdata = op[1] ? model[exp_addr[7:0]] : 32'h0BAD_0BAD;
      @(negedge clock);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0BAD_0BAD;
      if (op[0]) model[exp_addr[7:0]] = data;
      chk({tag, ".req_drop"},  {30'd0, mem_re, mem_we}, 32'd0);
      chk({tag, ".pilha_e"},   {31'd0, pilha_e},   32'd1);
      chk({tag, ".pop_valid"}, {31'd0, pop_valid}, {31'd0, op[1]});
      chk({tag, ".rp"},        rp,                 exp_rp);
      chk({tag, ".ready"},     {31'd0, ready},     32'd1);
      if (op[1]) chk({tag, ".pop_dado"}, pop_dado, exp_pop);
      @(negedge clock);
      chk({tag, ".pilha_e_1cyc"},   {31'd0, pilha_e},   32'd0);
      chk({tag, ".pop_valid_1cyc"}, {31'd0, pop_valid}, 32'd0);
      chk({tag, ".rp_stable"},      rp,                 exp_rp);
    end
  endtask

  initial begin
    //            op     data           dly addr     rp       pop            ov    un
    vecs[0] = '{2'd2, 32'h0000_0000, 0, 32'd0,   32'd224, 32'h0,         1'b0, 1'b1};
    vecs[1] = '{2'd1, 32'hDEAD_BEEF, 0, 32'd223, 32'd223, 32'h0,         1'b0, 1'b0};
    vecs[2] = '{2'd2, 32'h0000_0000, 3, 32'd223, 32'd224, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 32'h1234_5678, 0, 32'd0,   32'd224, 32'h0,         1'b0, 1'b0};
    vecs[4] = '{2'd1, 32'h1111_1111, 1, 32'd223, 32'd223, 32'h0,         1'b0, 1'b0};
    vecs[5] = '{2'd1, 32'h2222_2222, 2, 32'd222, 32'd222, 32'h0,         1'b0, 1'b0};
    vecs[6] = '{2'd3, 32'h3333_3333, 0, 32'd0,   32'd222, 32'h0,         1'b0, 1'b0};
    vecs[7] = '{2'd2, 32'h0000_0000, 0, 32'd222, 32'd223, 32'h2222_2222, 1'b0, 1'b0};
    vecs[8] = '{2'd2, 32'h0000_0000, 1, 32'd223, 32'd224, 32'h1111_1111, 1'b0, 1'b0};
    vecs[9] = '{2'd2, 32'h0000_0000, 0, 32'd0,   32'd224, 32'h0,         1'b0, 1'b1};

    for (int i = 0; i < 256; i++) model[i] = 32'hFFFF_FFFF;
    dado_push = 32'h0;
    mem_rdata = 32'h0BAD_0BAD;
    reset_n   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    mem_ack   = 1'b0;

    // Values held during reset
    @(negedge clock);
    chk("rst.rp",        rp,                 32'd224);
    chk("rst.mem_addr",  mem_addr,           32'd0);
    chk("rst.mem_wdata", mem_wdata,          32'd0);
    chk("rst.pop_dado",  pop_dado,           32'd0);
    chk("rst.strobes",   {26'd0, mem_we, mem_re, pilha_e, pop_valid, overflow, underflow}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle.ready", {31'd0, ready}, 32'd1);
    chk("idle.rp",    rp,             32'd224);

    // Table-driven single transactions
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].delay,
             vecs[i].exp_addr, vecs[i].exp_rp, vecs[i].exp_pop,
             vecs[i].exp_ov, vecs[i].exp_un);
    end

    // Pop requested while WAIT_W is busy must not run afterwards
    push      = 1'b1;
    dado_push = 32'h5A5A_5A5A;
    @(negedge clock);
    push = 1'b0;
    pop  = 1'b1;
    chk("wait_ign.mem_we", {31'd0, mem_we}, 32'd1);
    repeat (2) @(negedge clock);
    chk("wait_ign.mem_re_busy", {31'd0, mem_re}, 32'd0);
    mem_ack = 1'b1;
    pop     = 1'b0;
    @(negedge clock);
    mem_ack = 1'b0;
    model[223] = 32'h5A5A_5A5A;
    chk("wait_ign.rp",      rp,                32'd223);
    chk("wait_ign.pilha_e", {31'd0, pilha_e},  32'd1);
    repeat (2) begin
      @(negedge clock);
      chk("wait_ign.no_pop", {31'd0, mem_re}, 32'd0);
      chk("wait_ign.rp_hold", rp, 32'd223);
    end
    run_op("wait_ign.pop", 2'd2, 32'h0, 0, 32'd223, 32'd224, 32'h5A5A_5A5A, 1'b0, 1'b0);

    // Fill to full, refused push, drain in LIFO order
    do_reset();
    for (int i = 0; i < 64; i++) begin
      run_op($sformatf("fill%0d", i), 2'd1, 32'(i), i % 3, 32'(223 - i), 32'(223 - i),
             32'h0, 1'b0, 1'b0);
    end
    run_op("full.push", 2'd1, 32'd64, 0, 32'd0, 32'd160, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      run_op($sformatf("drain%0d", i), 2'd2, 32'h0, i % 2, 32'(160 + i), 32'(161 + i),
             32'(63 - i), 1'b0, 1'b0);
    end

    // Reset during WAIT_W with a late ack after release
    push      = 1'b1;
    dado_push = 32'hCAFE_F00D;
    @(negedge clock);
    push = 1'b0;
    chk("midrst.mem_we_pre", {31'd0, mem_we}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.mem_we_async", {31'd0, mem_we}, 32'd0);
    chk("midrst.rp_async",     rp,              32'd224);
    @(negedge clock);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("midrst.rp",      rp,               32'd224);
    chk("midrst.pilha_e", {31'd0, pilha_e}, 32'd0);
    chk("midrst.mem_we",  {31'd0, mem_we},  32'd0);
    chk("midrst.ready",   {31'd0, ready},   32'd1);
    @(negedge clock);
    chk("midrst.pilha_e2", {31'd0, pilha_e}, 32'd0);
    chk("midrst.rp2",      rp,               32'd224);

    // Watermark sequence: push 5, pop 3, push 1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("wm.push%0d", i), 2'd1, 32'(100 + i), 0, 32'(223 - i),
             32'(223 - i), 32'h0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      run_op($sformatf("wm.pop%0d", i), 2'd2, 32'h0, 0, 32'(219 + i), 32'(220 + i),
             32'(104 - i), 1'b0, 1'b0);
    end
    run_op("wm.push_last", 2'd1, 32'h0000_0077, 0, 32'd221, 32'd221, 32'h0, 1'b0, 1'b0);
    chk("wm.rp", rp, 32'd221);
`ifdef STACK_WATERMARK_EN
    chk("wm.max_depth", max_depth, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_pointer_unit.md
Name: stack_pointer_unit

Overview:
- Stack control unit sitting directly upstream of the register bank.
- Owns the authoritative stack pointer, runs PUSH/POP transactions against data memory through a req/ack handshake, and produces the new $rp value plus its one-cycle write strobe.
- The register bank mirrors $rp from those two outputs.
- Stack grows downward, one word per entry, from RP_TOP.

Parameters:
- RP_TOP, 224: reset value of the pointer (empty stack); matches the bank's initial $rp.
- STACK_BASE, 160: lowest legal entry address; pointer == STACK_BASE means full.
- ADDR_W, 32: width of pointer and memory address.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- push  in  1  push request, sampled only in IDLE.
- pop  in  1  pop request, sampled only in IDLE.
- dado_push  in  32  word to push; captured with push.
- ready  out  1  high in IDLE (request accepted this cycle).
- mem_addr  out  ADDR_W  memory address for the current transaction.
- mem_wdata  out  32  write data.
- mem_we  out  1  memory write request; held until ack.
- mem_re  out  1  memory read request; held until ack.
- mem_ack  in  1  memory completion; sampled only in WAIT_W/WAIT_R.
- mem_rdata  in  32  read data, valid with mem_ack.
- rp  out  ADDR_W  current stack pointer (connects to bank rp input).
- pilha_e  out  1  one-cycle strobe: bank must load rp (bank PilhaE).
- pop_dado  out  32  popped word.
- pop_valid  out  1  one-cycle strobe: pop_dado valid.
- overflow  out  1  one-cycle pulse: push refused, stack full.
- underflow  out  1  one-cycle pulse: pop refused, stack empty.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rp=RP_TOP.
  - mem_we, mem_re, pilha_e, pop_valid, overflow, underflow = 0.
  - mem_addr, mem_wdata, pop_dado = 0.
  - ready=1 once reset releases.
  - Reset mid-transaction drops mem_we/mem_re immediately. No partial rp update. A late mem_ack after reset is ignored.
- All outputs are registered. ready is decoded from state.
- FSM states: IDLE, WAIT_W, WAIT_R.
- IDLE, push=1 & pop=1: illegal; nothing started, no pulses, stay IDLE.
- IDLE, push only:
  - rp==STACK_BASE: overflow=1 for one cycle, stay IDLE.
  - Otherwise: mem_addr=rp-1, mem_wdata=dado_push, mem_we=1, go to WAIT_W (pre-decrement).
- IDLE, pop only:
  - rp==RP_TOP: underflow=1 for one cycle, stay IDLE.
  - Otherwise: mem_addr=rp, mem_re=1, go to WAIT_R (post-increment).
- WAIT_W, mem_ack=1 at an edge: rp<=rp-1, pilha_e=1 for one cycle, mem_we=0, go to IDLE.
- WAIT_R, mem_ack=1 at an edge: pop_dado<=mem_rdata, rp<=rp+1, pilha_e=1, pop_valid=1 (both one cycle), mem_re=0, go to IDLE.
- Wait states, mem_ack=0: hold mem_addr, mem_wdata and the request strobe stable. No timeout.
- Latency: request edge E0. Earliest ack edge E1. rp/pilha_e/pop_valid visible in the cycle after E1. ready is high in that same cycle, so a back-to-back request can be accepted at E2.
- rp only changes at an acked transaction or reset. It always stays in [STACK_BASE, RP_TOP].
- Arithmetic is ADDR_W-bit unsigned. Wrap-around is impossible because of the bounds checks.
- mem_we and mem_re are never high together.
- push/pop levels outside IDLE are ignored; they are not queued.

Optional Feature:
- Macro STACK_WATERMARK_EN.
- When defined, add output max_depth [ADDR_W-1:0]:
  - Reset to 0.
  - On every push commit, if (RP_TOP - new rp) > max_depth, load it.
  - Never decreases except on reset.
- When undefined: port absent, no extra logic. All other behaviour is identical.

Test Plan:
- Reset then idle: rp=224, ready=1, all strobes 0. Pop -> underflow pulse of exactly one cycle, rp stays 224, mem_re never asserted.
- Push 0xDEADBEEF, mem_ack one cycle later -> mem_addr=223, mem_we for 1 cycle, then rp=223 with pilha_e pulse of 1 cycle. Then pop with ack after 3 wait cycles -> mem_addr=223 held 3 cycles, pop_dado=0xDEADBEEF, pop_valid and pilha_e together, rp=224.
- 64 consecutive pushes (values 0..63) reach rp=160. 65th push -> overflow pulse, no mem_we, rp=160. 64 pops return 63..0 in order.
- push and pop both high in IDLE -> no memory request, no pulses, rp unchanged. Requests asserted while in WAIT_W are not executed afterwards.
- Push issued, reset_n pulsed low during WAIT_W with mem_ack arriving after release -> mem_we drops asynchronously, rp=224, no pilha_e.
- With STACK_WATERMARK_EN: push 5, pop 3, push 1 -> max_depth=5. Without the macro, the same sequence passes the rp checks and elaborates with no max_depth port.
